// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared types, pattern encodings and pattern generator for the memory BIST master
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_SEL_ADDR  = 2'd0,
    PAT_SEL_NADDR = 2'd1,
    PAT_SEL_A5    = 2'd2,
    PAT_SEL_5A    = 2'd3
  } pat_sel_e;

  localparam logic [31:0] PAT_A5 = 32'hA5A5_A5A5;
  localparam logic [31:0] PAT_5A = 32'h5A5A_5A5A;

  // Address-derived patterns are confined to addr_w bits so ~addr zero-extends cleanly.
  function automatic logic [31:0] pattern_word(input logic [1:0] sel, input logic [31:0] addr,
                                               input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
    case (sel)
      PAT_SEL_ADDR:  return addr & mask;
      PAT_SEL_NADDR: return ~addr & mask;
      PAT_SEL_A5:    return PAT_A5;
      default:       return PAT_5A;
    endcase
  endfunction

endpackage

// File: rtl/avmm_mem_bist_master_if.sv
// rtl/avmm_mem_bist_master_if.sv - Avalon-MM bus between the BIST master and the memory slave port
interface avmm_mem_bist_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_read;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/mem_bist_rd_pipe.sv
// rtl/mem_bist_rd_pipe.sv - fixed-depth shift pipe carrying {valid, addr, expected} to line up with read data
module mem_bist_rd_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_exp,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [DATA_W-1:0] pop_exp
);

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] exp_q  [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= push_valid;
      addr_q[0] <= push_addr;
      exp_q[0]  <= push_exp;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign pop_valid = vld_q[DEPTH-1];
  assign pop_addr  = addr_q[DEPTH-1];
  assign pop_exp   = exp_q[DEPTH-1];

endmodule

// File: rtl/avmm_mem_bist_master.sv
// rtl/avmm_mem_bist_master.sv - Avalon-MM memory BIST master: fill, read back, compare (option MEM_BIST_WAITREQ_EN)
module avmm_mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERRCNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         word_count,
  input  logic [1:0]              pattern_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERRCNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]       first_err_addr,
  avmm_mem_bist_master_if.master  avm
);

  localparam logic [ADDR_W:0]     IDX_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]     DRAIN_LAST = (ADDR_W+1)'(READ_LATENCY - 1);
  localparam logic [ERRCNT_W-1:0] ERR_ONE    = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  state_e               state, state_nxt;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W:0]      count_q;
  logic [1:0]           sel_q;
  logic [ADDR_W:0]      idx_q, idx_nxt;
  logic [ERRCNT_W-1:0]  err_q;
  logic [ADDR_W-1:0]    first_err_q;
  logic                 pass_q;
  logic                 latch_cfg;
  logic                 req, accept, last_beat;
  logic [ADDR_W-1:0]    beat_addr;
  logic [DATA_W-1:0]    beat_data;
  logic                 pop_valid, mismatch;
  logic [ADDR_W-1:0]    pop_addr;
  logic [DATA_W-1:0]    pop_exp;

  // Address and data depend only on state and beat index, so they hold naturally during a stall.
  assign beat_addr = base_q + idx_q[ADDR_W-1:0];
  assign beat_data = DATA_W'(pattern_word(sel_q, 32'(beat_addr), ADDR_W));
  assign req       = (state == WRITE) || (state == READ);
  assign last_beat = (idx_q == count_q - IDX_ONE);

`ifdef MEM_BIST_WAITREQ_EN
  assign accept = req && !avm.avm_waitrequest;
`else
  logic unused_waitreq;
  assign unused_waitreq = avm.avm_waitrequest;
  assign accept         = req;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    latch_cfg = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          idx_nxt   = '0;
          state_nxt = (word_count == '0) ? DONE : WRITE;
        end
      end
      WRITE, READ: begin
        if (accept) begin
          if (last_beat) begin
            idx_nxt   = '0;
            state_nxt = (state == WRITE) ? READ : DRAIN;
          end else begin
            idx_nxt = idx_q + IDX_ONE;
          end
        end
      end
      DRAIN: begin
        if (idx_q == DRAIN_LAST) state_nxt = DONE;
        else                     idx_nxt   = idx_q + IDX_ONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      count_q     <= '0;
      sel_q       <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      if (latch_cfg) begin
        base_q      <= base_addr;
        count_q     <= word_count;
        sel_q       <= pattern_sel;
        err_q       <= '0;
        first_err_q <= '0;
        pass_q      <= 1'b0;
      end else if (mismatch) begin
        if (err_q != '1) err_q <= err_q + ERR_ONE;
        if (err_q == '0) first_err_q <= pop_addr;
      end
      if (state == DONE) pass_q <= (err_q == '0);
    end
  end

  mem_bist_rd_pipe #(
    .DEPTH  (READ_LATENCY),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (accept && (state == READ)),
    .push_addr  (beat_addr),
    .push_exp   (beat_data),
    .pop_valid  (pop_valid),
    .pop_addr   (pop_addr),
    .pop_exp    (pop_exp)
  );

  assign mismatch = pop_valid && (avm.avm_readdata != pop_exp);

  assign avm.avm_address    = req ? beat_addr : '0;
  assign avm.avm_byteenable = '1;
  assign avm.avm_chipselect = req;
  assign avm.avm_write      = (state == WRITE);
  assign avm.avm_read       = (state == READ);
  assign avm.avm_writedata  = (state == WRITE) ? beat_data : '0;

  assign busy           = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done           = (state == DONE);
  assign pass           = done ? (err_q == '0) : pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_avmm_mem_bist_master.sv
// tb/tb_avmm_mem_bist_master.sv - scoreboard bench for avmm_mem_bist_master with a registered memory model
module tb_avmm_mem_bist_master;

  localparam int ADDR_W = 12, DATA_W = 32, RL = 1, ERRCNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, start, busy, done, pass;
  logic [ADDR_W-1:0]   base_addr, first_err_addr;
  logic [ADDR_W:0]     word_count;
  logic [1:0]          pattern_sel;
  logic [ERRCNT_W-1:0] err_count;

  avmm_mem_bist_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  avmm_mem_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .ERRCNT_W(ERRCNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .pattern_sel(pattern_sel), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm(avm)
  );

  typedef struct { bit wr; logic [11:0] addr; logic [31:0] data; } beat_t;
  typedef struct { bit pass; logic [15:0] err; logic [11:0] first; int cycles; } result_t;

  beat_t   exp_beats[$];
  result_t res_q[$];
  int      tests = 0, fails = 0, bus_beats = 0;
  bit      fault_en = 0, stall_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_pattern(input logic [1:0] s, input logic [11:0] a);
    case (s)
      2'd0:    return {20'd0, a};
      2'd1:    return {20'd0, ~a};
      2'd2:    return 32'hA5A5A5A5;
      default: return 32'h5A5A5A5A;
    endcase
  endfunction

  // Memory slave: registered read with RL cycles of latency, optional single-bit fault on word 5.
  logic [31:0] mem [0:4095];
  logic [31:0] rd_stage [RL];
  always @(posedge clk) begin
    if (avm.avm_chipselect && avm.avm_write && !avm.avm_waitrequest)
      mem[avm.avm_address] <= avm.avm_writedata;
    rd_stage[0] <= (avm.avm_chipselect && avm.avm_read && !avm.avm_waitrequest)
                 ? (mem[avm.avm_address] ^ ((fault_en && avm.avm_address == 12'd5) ? 32'h8 : 32'h0))
                 : 32'hx;
    for (int i = 1; i < RL; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign avm.avm_readdata = rd_stage[RL-1];

  always @(posedge clk) begin
    #1;
`ifdef MEM_BIST_WAITREQ_EN
    avm.avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
`else
    avm.avm_waitrequest = 1'b0;
`endif
  end

  // Bus monitor: every accepted beat must match the next expected beat; stalled requests must hold.
  bit          prev_stall = 0, snap_wr = 0;
  logic [11:0] snap_addr = '0;
  logic [31:0] snap_data = '0;
  always @(negedge clk) begin
    if (reset_n && (avm.avm_write || avm.avm_read)) begin
      chk("chipselect", 32'(avm.avm_chipselect), 32'd1);
      chk("byteenable", 32'(avm.avm_byteenable), 32'hF);
      if (prev_stall) begin
        chk("hold_addr", 32'(avm.avm_address), 32'(snap_addr));
        chk("hold_wr", 32'(avm.avm_write), 32'(snap_wr));
        chk("hold_wdata", avm.avm_writedata, snap_data);
      end
      if (!avm.avm_waitrequest) begin
        bus_beats++;
        chk("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
        if (exp_beats.size() != 0) begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("beat_kind", 32'(avm.avm_write), 32'(e.wr));
          chk("beat_addr", 32'(avm.avm_address), 32'(e.addr));
          if (e.wr) chk("beat_wdata", avm.avm_writedata, e.data);
        end
      end
      prev_stall <= avm.avm_waitrequest;
      snap_addr  <= avm.avm_address;
      snap_wr    <= avm.avm_write;
      snap_data  <= avm.avm_writedata;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic push_beats(input logic [11:0] b, input logic [12:0] n, input logic [1:0] s);
    logic [11:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 12'(i);
      exp_beats.push_back('{1'b1, a, tb_pattern(s, a)});
    end
    for (int i = 0; i < int'(n); i++) begin
      a = b + 12'(i);
      exp_beats.push_back('{1'b0, a, 32'h0});
    end
  endtask

  task automatic run_test(input string tag, input logic [11:0] b, input logic [12:0] n, input logic [1:0] s,
                          input bit fault, input bit poke, input bit exp_pass, input logic [15:0] exp_err,
                          input logic [11:0] exp_first, input int exp_cycles);
    result_t r;
    int      cyc, beats0;
    bit      seen;
    push_beats(b, n, s);
    res_q.push_back('{exp_pass, exp_err, exp_first, exp_cycles});
    fault_en    = fault;
    beats0      = bus_beats;
    base_addr   = b;
    word_count  = n;
    pattern_sel = s;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 1;
    seen = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      if (poke && cyc == 3) begin start = 1'b1; word_count = '0; base_addr = 12'h123; end
      if (poke && cyc == 4) start = 1'b0;
      if (done) begin seen = 1; break; end
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    r = res_q.pop_front();
    if (seen) begin
      if (r.cycles >= 0) chk({tag, "_cycles"}, 32'(cyc), 32'(r.cycles));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'(r.pass));
      chk({tag, "_err_count"}, 32'(err_count), 32'(r.err));
      chk({tag, "_first_err"}, 32'(first_err_addr), 32'(r.first));
      chk({tag, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
      chk({tag, "_beat_count"}, 32'(bus_beats - beats0), 32'(2 * int'(n)));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_pass_held"}, 32'(pass), 32'(r.pass));
    end
    fault_en = 0;
    exp_beats.delete();
  endtask

  initial begin
    bit saw_done;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; pattern_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", 32'(first_err_addr), 32'd0);
    chk("rst_bus", 32'({avm.avm_write, avm.avm_read, avm.avm_chipselect}), 32'd0);
    chk("rst_addr", 32'(avm.avm_address), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test("t1_addr", 12'h000, 13'd16, 2'd0, 0, 0, 1, 16'd0, 12'h000, 34);
    run_test("t2_fault", 12'h000, 13'd16, 2'd2, 1, 0, 0, 16'd1, 12'h005, 34);
    run_test("t3_wrap", 12'hFFE, 13'd4, 2'd1, 0, 0, 1, 16'd0, 12'h000, 10);
    stall_en = 1;
`ifdef MEM_BIST_WAITREQ_EN
    run_test("t4_stall", 12'h040, 13'd24, 2'd3, 0, 0, 1, 16'd0, 12'h000, -1);
`else
    run_test("t4_stall", 12'h040, 13'd24, 2'd3, 0, 0, 1, 16'd0, 12'h000, 50);
`endif
    stall_en = 0;
    repeat (2) @(negedge clk);
    run_test("t5_zero", 12'h200, 13'd0, 2'd0, 0, 0, 1, 16'd0, 12'h000, 1);
    run_test("t5_poke", 12'h300, 13'd8, 2'd0, 0, 1, 1, 16'd0, 12'h000, 18);

    // Abort mid-WRITE with reset, then confirm a clean rerun.
    push_beats(12'h100, 13'd20, 2'd0);
    base_addr = 12'h100; word_count = 13'd20; pattern_sel = 2'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    chk("t6_write_before", 32'(avm.avm_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_bus", 32'({avm.avm_write, avm.avm_read, avm.avm_chipselect}), 32'd0);
    chk("t6_rst_addr", 32'(avm.avm_address), 32'd0);
    chk("t6_rst_wdata", avm.avm_writedata, 32'd0);
    chk("t6_rst_status", 32'({busy, done, pass}), 32'd0);
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    chk("t6_no_done", 32'(saw_done), 32'd0);
    exp_beats.delete();
    run_test("t6_rerun", 12'h100, 13'd20, 2'd0, 0, 0, 1, 16'd0, 12'h000, 42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
